// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an RV32I instruction into ALU control and operands and
// holds them in a one-entry valid/ready pipeline register with stall and flush.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALU_Control,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      branch,
  output logic            illegal
);

  typedef enum logic [3:0] {
    AluAdd = 4'b0000,
    AluSub = 4'b0001,
    AluAnd = 4'b0010,
    AluOr  = 4'b0011,
    AluSll = 4'b0100,
    AluSrl = 4'b0101
  } alu_op_e;

  typedef enum logic [1:0] {
    BrNone = 2'b00,
    BrEq   = 2'b01,
    BrNe   = 2'b10
  } branch_e;

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] store_data;
    logic [3:0]      alu;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      branch;
    logic            illegal;
  } payload_t;

  // The PC is carried on the interface for future use; nothing here consumes it.
  logic unused_pc;
  assign unused_pc = ^pc;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            f7_base;
  logic            f7_alt;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign f7_base = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign imm_i   = XLEN'($signed(instr[31:20]));
  assign imm_s   = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_u   = XLEN'($signed({instr[31:12], 12'b0}));
  assign shamt   = XLEN'(instr[24:20]);

  payload_t dec;
  logic     legal;
  logic     wants_write;

  always_comb begin
    dec            = '0;
    dec.alu        = AluAdd;
    dec.branch     = BrNone;
    dec.rd         = instr[11:7];
    dec.store_data = rs2_data;
    legal          = 1'b0;
    wants_write    = 1'b0;

    unique case (opcode)
      OpReg: begin
        dec.a       = rs1_data;
        dec.b       = rs2_data;
        wants_write = 1'b1;
        case (funct3)
          3'b000: begin
            legal   = f7_base | f7_alt;
            dec.alu = f7_alt ? AluSub : AluAdd;
          end
          3'b111: begin
            legal   = f7_base;
            dec.alu = AluAnd;
          end
          3'b110: begin
            legal   = f7_base;
            dec.alu = AluOr;
          end
          3'b001: begin
            legal   = f7_base;
            dec.alu = AluSll;
          end
          3'b101: begin
            legal   = f7_base;
            dec.alu = AluSrl;
          end
          default: legal = 1'b0;
        endcase
      end

      OpImm: begin
        dec.a       = rs1_data;
        dec.b       = imm_i;
        wants_write = 1'b1;
        case (funct3)
          3'b000: begin
            legal   = 1'b1;
            dec.alu = AluAdd;
          end
          3'b111: begin
            legal   = 1'b1;
            dec.alu = AluAnd;
          end
          3'b110: begin
            legal   = 1'b1;
            dec.alu = AluOr;
          end
          3'b001: begin
            legal   = f7_base;
            dec.alu = AluSll;
            dec.b   = shamt;
          end
          // SRAI (funct7 0100000) falls out as illegal here.
          3'b101: begin
            legal   = f7_base;
            dec.alu = AluSrl;
            dec.b   = shamt;
          end
          default: legal = 1'b0;
        endcase
      end

      OpLoad: begin
        legal        = (funct3 == 3'b010);
        dec.a        = rs1_data;
        dec.b        = imm_i;
        dec.mem_read = 1'b1;
        wants_write  = 1'b1;
      end

      OpStore: begin
        legal         = (funct3 == 3'b010);
        dec.a         = rs1_data;
        dec.b         = imm_s;
        dec.mem_write = 1'b1;
      end

      OpBranch: begin
        dec.a   = rs1_data;
        dec.b   = rs2_data;
        dec.alu = AluSub;
        case (funct3)
          3'b000: begin
            legal      = 1'b1;
            dec.branch = BrEq;
          end
          3'b001: begin
            legal      = 1'b1;
            dec.branch = BrNe;
          end
          default: legal = 1'b0;
        endcase
      end

      OpLui: begin
        legal       = 1'b1;
        dec.a       = '0;
        dec.b       = imm_u;
        wants_write = 1'b1;
      end

      default: legal = 1'b0;
    endcase

    dec.reg_write = wants_write & (dec.rd != 5'd0);

    // Unsupported encodings still occupy the slot so downstream trap logic sees them.
    if (!legal) begin
      dec.a         = '0;
      dec.b         = '0;
      dec.alu       = AluAdd;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch    = BrNone;
      dec.illegal   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline register
  // ---------------------------------------------------------------------------
  logic     valid_d, valid_q;
  payload_t payload_d, payload_q;
  logic     load;

  assign in_ready = ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      payload_d = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign A           = payload_q.a;
  assign B           = payload_q.b;
  assign ALU_Control = payload_q.alu;
  assign store_data  = payload_q.store_data;
  assign rd          = payload_q.rd;
  assign reg_write   = payload_q.reg_write;
  assign mem_read    = payload_q.mem_read;
  assign mem_write   = payload_q.mem_write;
  assign branch      = payload_q.branch;
  assign illegal     = payload_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, stall, flush, streaming and
// asynchronous reset, each checked against hand-computed values.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_Control;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  branch;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A          (A),
    .B          (B),
    .ALU_Control(ALU_Control),
    .store_data (store_data),
    .rd         (rd),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic check_core(input string tag, input logic [3:0] alu, input logic [31:0] a,
                            input logic [31:0] b, input logic rw);
    check_eq({tag, ".valid"}, out_valid, 1'b1);
    check_eq({tag, ".alu"}, ALU_Control, alu);
    check_eq({tag, ".A"}, A, a);
    check_eq({tag, ".B"}, B, b);
    check_eq({tag, ".rw"}, reg_write, rw);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    pc        = '0;
    rs1_data  = '0;
    rs2_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check_eq("rst.valid", out_valid, 1'b0);
    check_eq("rst.alu", ALU_Control, 4'b0000);
    check_eq("rst.A", A, 32'h0);
    check_eq("rst.B", B, 32'h0);
    check_eq("rst.rw", reg_write, 1'b0);
    check_eq("rst.in_ready", in_ready, 1'b1);
    step();
    step();
    rst = 1'b0;

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'd5, 32'd7);
    out_ready = 1'b1;
    step();
    check_core("add", 4'b0000, 32'd5, 32'd7, 1'b1);
    check_eq("add.rd", rd, 32'd3);
    check_eq("add.illegal", illegal, 1'b0);

    // SUB accepted, then stalled for three cycles while ADDI waits upstream
    drive(32'h402081B3, 32'd9, 32'd4);
    step();
    check_core("sub", 4'b0001, 32'd9, 32'd4, 1'b1);
    out_ready = 1'b0;
    drive(32'hFFF00093, 32'd0, 32'h55);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("stall.in_ready", in_ready, 1'b0);
      step();
      check_core("stall", 4'b0001, 32'd9, 32'd4, 1'b1);
      check_eq("stall.rd", rd, 32'd3);
    end
    out_ready = 1'b1;
    #1;
    check_eq("unstall.in_ready", in_ready, 1'b1);
    step();
    check_core("addi", 4'b0000, 32'd0, 32'hFFFF_FFFF, 1'b1);
    check_eq("addi.rd", rd, 32'd1);

    // SLLI x1,x1,4
    drive(32'h00409093, 32'h10, 32'd0);
    step();
    check_core("slli", 4'b0100, 32'h10, 32'd4, 1'b1);

    // SRAI is unsupported
    drive(32'h40405093, 32'h10, 32'd0);
    step();
    check_core("srai", 4'b0000, 32'd0, 32'd0, 1'b0);
    check_eq("srai.illegal", illegal, 1'b1);
    check_eq("srai.mr", mem_read, 1'b0);

    // SW x2,8(x1)
    drive(32'h0020A423, 32'h100, 32'hDEAD);
    step();
    check_core("sw", 4'b0000, 32'h100, 32'd8, 1'b0);
    check_eq("sw.mw", mem_write, 1'b1);
    check_eq("sw.mr", mem_read, 1'b0);
    check_eq("sw.sdata", store_data, 32'hDEAD);
    check_eq("sw.illegal", illegal, 1'b0);

    // LUI x5,0x12345
    drive(32'h123452B7, 32'h777, 32'd0);
    step();
    check_core("lui", 4'b0000, 32'd0, 32'h1234_5000, 1'b1);
    check_eq("lui.rd", rd, 32'd5);
    check_eq("lui.mw", mem_write, 1'b0);

    // LW x4,-4(x1)
    drive(32'hFFC0A203, 32'h200, 32'd0);
    step();
    check_core("lw", 4'b0000, 32'h200, 32'hFFFF_FFFC, 1'b1);
    check_eq("lw.mr", mem_read, 1'b1);
    check_eq("lw.rd", rd, 32'd4);

    // BNE x1,x2 then BEQ x1,x2
    drive(32'h00209063, 32'd3, 32'd4);
    step();
    check_core("bne", 4'b0001, 32'd3, 32'd4, 1'b0);
    check_eq("bne.branch", branch, 2'b10);
    drive(32'h00208063, 32'd6, 32'd6);
    step();
    check_core("beq", 4'b0001, 32'd6, 32'd6, 1'b0);
    check_eq("beq.branch", branch, 2'b01);

    // ADD x0,x1,x2: write to x0 suppressed
    drive(32'h00208033, 32'd1, 32'd2);
    step();
    check_core("add_x0", 4'b0000, 32'd1, 32'd2, 1'b0);
    check_eq("add_x0.rd", rd, 32'd0);
    check_eq("add_x0.branch", branch, 2'b00);

    // Flush with a held entry and a same-cycle input
    out_ready = 1'b0;
    drive(32'h002081B3, 32'd11, 32'd12);
    flush = 1'b1;
    step();
    check_eq("flush.valid", out_valid, 1'b0);
    check_eq("flush.A_held", A, 32'd1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check_eq("flush.after", out_valid, 1'b0);

    // Eight back-to-back ADDI x<i>,x0,<i>
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive((32'(i) << 20) | (32'(i) << 7) | 32'h13, 32'd0, 32'd0);
      step();
      check_eq("b2b.valid", out_valid, 1'b1);
      check_eq("b2b.B", B, 32'(i));
      check_eq("b2b.rd", rd, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check_eq("b2b.drain", out_valid, 1'b0);

    // Asynchronous reset while stalled
    drive(32'h002081B3, 32'd5, 32'd7);
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    step();
    check_eq("rst_stall.held", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_stall.valid", out_valid, 1'b0);
    check_eq("rst_stall.A", A, 32'd0);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
